// File: rtl/dom_pkg.sv
// Shared constants and types for the DOM fresh-mask PRNG: LFSR polynomial,
// mask-word field offsets and the sequencing FSM encoding.
package dom_pkg;

    // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    localparam int RAND_Z_LSB  = 0;
    localparam int RAND_Y_LSB  = 2;
    localparam int RAND_Z2_LSB = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEED = 2'd1,
        WARM = 2'd2,
        RUN  = 2'd3
    } dom_state_e;

    // The all-zero state locks the LFSR, so a zero seed is promoted to 1.
    function automatic logic [31:0] seed_fix(input logic [31:0] s);
        return (s == 32'h0) ? 32'h0000_0001 : s;
    endfunction

endpackage

// File: rtl/dom_lfsr_step.sv
// Combinational unroll of RAND_W Galois LFSR steps; bit i of the word is the
// output bit of step i.
module dom_lfsr_step
    import dom_pkg::*;
#(
    parameter int LFSR_W = 32,
    parameter int RAND_W = 6
) (
    input  logic [LFSR_W-1:0] state_in,
    output logic [LFSR_W-1:0] state_out,
    output logic [RAND_W-1:0] bits
);

    logic [LFSR_W-1:0] s;

    always_comb begin
        s    = state_in;
        bits = '0;
        for (int i = 0; i < RAND_W; i++) begin
            bits[i] = s[0];
            s = (s >> 1) ^ (s[0] ? LFSR_W'(LFSR_POLY) : '0);
        end
        state_out = s;
    end

endmodule

// File: rtl/dom_mask_prng.sv
// Fresh-mask generator for the DOM-dep GF(2^2) multiplier: seeded LFSR with
// warm-up, a single-register valid/ready output stage and a reseed request.
//
// state | meaning
// IDLE  | no seed loaded since reset, output stage silent
// SEED  | one-cycle pause after a seed capture
// WARM  | generating and discarding WARMUP words
// RUN   | output register refills whenever empty or consumed
module dom_mask_prng
    import dom_pkg::*;
#(
    parameter int LFSR_W          = 32,
    parameter int RAND_W          = 6,
    parameter int WARMUP          = 64,
    parameter int RESEED_INTERVAL = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              seed_valid,
    input  logic [LFSR_W-1:0] seed_data,
    input  logic              rand_ready,
    output logic              rand_valid,
    output logic [RAND_W-1:0] rand_data,
    output logic              reseed_req,
    output logic              busy
);

    localparam int WARM_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
    localparam int CNT_W  = (RESEED_INTERVAL > 0) ? $clog2(RESEED_INTERVAL + 1) : 1;

    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'((WARMUP > 0) ? WARMUP - 1 : 0);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'((RESEED_INTERVAL > 0) ? RESEED_INTERVAL - 1 : 0);
    localparam logic [CNT_W-1:0]  CNT_SAT   = CNT_W'(RESEED_INTERVAL);

    dom_state_e state, state_nxt;

    logic [LFSR_W-1:0] lfsr;
    logic [LFSR_W-1:0] step_state;
    logic [RAND_W-1:0] step_bits;
    logic [WARM_W-1:0] warm_cnt;
    logic [CNT_W-1:0]  deliv_cnt;
    logic              load;
    logic              handshake;

    dom_lfsr_step #(
        .LFSR_W (LFSR_W),
        .RAND_W (RAND_W)
    ) u_step (
        .state_in  (lfsr),
        .state_out (step_state),
        .bits      (step_bits)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (seed_valid) begin
            state_nxt = SEED;
        end else begin
            case (state)
                IDLE: state_nxt = IDLE;
                SEED: state_nxt = (WARMUP > 0) ? WARM : RUN;
                WARM: if (warm_cnt == WARM_LAST) state_nxt = RUN;
                RUN:  state_nxt = RUN;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // A seed in the same cycle as a handshake wins: the word is dropped, not delivered.
    assign load      = (state == RUN) && (!rand_valid || rand_ready) && !seed_valid;
    assign handshake = rand_valid && rand_ready && !seed_valid;
    assign busy      = (state == SEED) || (state == WARM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr       <= '0;
            rand_valid <= 1'b0;
            rand_data  <= '0;
            reseed_req <= 1'b1;
            warm_cnt   <= '0;
            deliv_cnt  <= '0;
        end else if (seed_valid) begin
            lfsr       <= seed_fix(seed_data);
            rand_valid <= 1'b0;
            reseed_req <= 1'b0;
            warm_cnt   <= '0;
            deliv_cnt  <= '0;
        end else begin
            if (state == WARM) begin
                lfsr     <= step_state;
                warm_cnt <= warm_cnt + 1'b1;
            end
            if (load) begin
                lfsr       <= step_state;
                rand_data  <= step_bits;
                rand_valid <= 1'b1;
            end
            if (handshake && (deliv_cnt != CNT_SAT)) begin
                deliv_cnt <= deliv_cnt + 1'b1;
            end
            if ((RESEED_INTERVAL != 0) && handshake && (deliv_cnt == CNT_LAST)) begin
                reseed_req <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dom_mask_prng.sv
// Directed bench for dom_mask_prng: one instance with no warm-up and a short
// reseed interval, one with the default warm-up and interval.
`timescale 1ns/1ps
module tb_dom_mask_prng;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        sv0, rr0, rv0, rq0, bz0;
    logic [31:0] sd0;
    logic [5:0]  rd0;

    logic        sv1, rr1, rv1, rq1, bz1;
    logic [31:0] sd1;
    logic [5:0]  rd1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dom_mask_prng #(.WARMUP(0), .RESEED_INTERVAL(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .seed_valid(sv0), .seed_data(sd0),
        .rand_ready(rr0), .rand_valid(rv0), .rand_data(rd0),
        .reseed_req(rq0), .busy(bz0)
    );

    dom_mask_prng dut1 (
        .clk(clk), .rst_n(rst_n), .seed_valid(sv1), .seed_data(sd1),
        .rand_ready(rr1), .rand_valid(rv1), .rand_data(rd1),
        .reseed_req(rq1), .busy(bz1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Independent reference: six right-shift Galois steps, poly 0x80200003.
    function automatic logic [31:0] mstep(input logic [31:0] s, output logic [5:0] w);
        logic [31:0] t;
        t = s;
        w = '0;
        for (int i = 0; i < 6; i++) begin
            w[i] = t[0];
            t = {1'b0, t[31:1]} ^ (t[0] ? 32'h8020_0003 : 32'h0);
        end
        return t;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] m;
        logic [5:0]  w;
        logic [5:0]  w_first;
        int          n;

        rst_n = 1'b0;
        sv0 = 1'b0; sd0 = '0; rr0 = 1'b0;
        sv1 = 1'b0; sd1 = '0; rr1 = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;

        // reset, no seed: stays quiet
        repeat (5) tick();
        chk("rst_valid", 32'(rv0), 32'h0);
        chk("rst_data", 32'(rd0), 32'h0);
        chk("rst_reseed", 32'(rq0), 32'h1);
        chk("rst_busy", 32'(bz0), 32'h0);
        chk("rst_lfsr", dut0.lfsr, 32'h0);
        chk("rst_valid1", 32'(rv1), 32'h0);

        // seed 1, WARMUP=0: first word two edges after seed capture
        rr0 = 1'b1; sv0 = 1'b1; sd0 = 32'h0000_0001;
        tick();
        sv0 = 1'b0;
        chk("a_busy_seed", 32'(bz0), 32'h1);
        chk("a_valid_seed", 32'(rv0), 32'h0);
        chk("a_reseed_clr", 32'(rq0), 32'h0);
        tick();
        chk("a_valid_run0", 32'(rv0), 32'h0);
        chk("a_busy_run0", 32'(bz0), 32'h0);
        tick();
        chk("a_valid_first", 32'(rv0), 32'h1);
        chk("a_word_first", 32'(rd0), 32'h1B);
        chk("a_lfsr_first", dut0.lfsr, 32'h6C1B_0001);
        m = 32'h6C1B_0001;
        for (int i = 1; i <= 6; i++) begin
            m = mstep(m, w);
            tick();
            chk($sformatf("a_word%0d", i), 32'(rd0), 32'(w));
            chk($sformatf("a_reseed%0d", i), 32'(rq0), (i >= 4) ? 32'h1 : 32'h0);
        end

        // seed 0 is promoted to 1: identical stream
        sv0 = 1'b1; sd0 = 32'h0;
        tick();
        sv0 = 1'b0;
        chk("z_valid_drop", 32'(rv0), 32'h0);
        chk("z_busy", 32'(bz0), 32'h1);
        chk("z_reseed_clr", 32'(rq0), 32'h0);
        tick();
        tick();
        chk("z_word_first", 32'(rd0), 32'h1B);
        m = 32'h6C1B_0001;
        for (int i = 1; i <= 3; i++) begin
            m = mstep(m, w);
            tick();
            chk($sformatf("z_word%0d", i), 32'(rd0), 32'(w));
        end
        chk("z_reseed_3hs", 32'(rq0), 32'h0);

        // ready pattern 1,0,0,1: word held, LFSR frozen, nothing skipped
        m = mstep(m, w);
        tick();
        chk("s_w1", 32'(rd0), 32'(w));
        chk("s_reseed_4hs", 32'(rq0), 32'h1);
        rr0 = 1'b0;
        tick();
        chk("s_hold1", 32'(rd0), 32'(w));
        chk("s_lfsr_frozen", dut0.lfsr, m);
        tick();
        chk("s_hold2", 32'(rd0), 32'(w));
        chk("s_valid_hold", 32'(rv0), 32'h1);
        rr0 = 1'b1;
        m = mstep(m, w);
        tick();
        chk("s_w2", 32'(rd0), 32'(w));

        // reseed mid-RUN with a pending word and ready low
        rr0 = 1'b0;
        tick();
        chk("r_pending_valid", 32'(rv0), 32'h1);
        chk("r_pending_data", 32'(rd0), 32'(w));
        sv0 = 1'b1; sd0 = 32'h1234_5678;
        tick();
        sv0 = 1'b0; rr0 = 1'b1;
        chk("r_valid_drop", 32'(rv0), 32'h0);
        chk("r_busy", 32'(bz0), 32'h1);
        chk("r_reseed_clr", 32'(rq0), 32'h0);
        tick();
        tick();
        m = mstep(32'h1234_5678, w);
        chk("r_word_first", 32'(rd0), 32'(w));
        chk("r_lfsr_first", dut0.lfsr, m);

        // default WARMUP=64: reseed mid-WARM, then time first word
        w_first = '0;
        m = 32'h0000_0001;
        for (int i = 0; i < 65; i++) m = mstep(m, w_first);

        rr1 = 1'b1; sv1 = 1'b1; sd1 = 32'hDEAD_BEEF;
        tick();
        sv1 = 1'b0;
        repeat (10) tick();
        chk("w_busy_warm", 32'(bz1), 32'h1);
        sv1 = 1'b1; sd1 = 32'h0000_0001;
        tick();
        sv1 = 1'b0;
        chk("w_busy_reseed", 32'(bz1), 32'h1);
        chk("w_lfsr_reload", dut1.lfsr, 32'h0000_0001);
        n = 0;
        while (n < 100) begin
            tick();
            n++;
            if (rv1) break;
        end
        chk("w_latency", 32'(n), 32'd66);
        chk("w_word_first", 32'(rd1), 32'(w_first));
        chk("w_reseed", 32'(rq1), 32'h0);
        chk("w_busy_run", 32'(bz1), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
